// File: rtl/hazard_pkg.sv
// Shared widths, defaults and the tracked-entry layout for the hazard/forwarding unit.
package hazard_pkg;

    localparam int DEF_REG_AW   = 5;
    localparam int DEF_STAGES   = 3;
    localparam int DEF_TW       = 2;
    localparam int DEF_MULT_LAT = 5;
    localparam int DEF_DIV_LAT  = 10;

    // Forward select value meaning "take the register file / pipeline register value".
    localparam int FWD_RF = 0;

    typedef struct packed {
        logic [DEF_REG_AW-1:0] dst;
        logic [DEF_TW-1:0]     tnew;
        logic                  md;
        logic                  div;
    } hz_entry_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/hazard_stage_reg.sv
// One tracked pipeline stage: holds the in-flight destination, its result countdown and
// the mult/div start flags. The first stage loads Tnew as issued and can take a bubble.
module hazard_stage_reg
    import hazard_pkg::*;
#(
    parameter int REG_AW   = DEF_REG_AW,
    parameter int TW       = DEF_TW,
    parameter bit LOAD_RAW = 1'b0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_bubble,
    input  logic [REG_AW-1:0] i_dst,
    input  logic [TW-1:0]     i_tnew,
    input  logic              i_md,
    input  logic              i_div,
    output logic [REG_AW-1:0] o_dst,
    output logic [TW-1:0]     o_tnew,
    output logic              o_md,
    output logic              o_div
);

    logic [REG_AW-1:0] r_dst;
    logic [TW-1:0]     r_tnew;
    logic              r_md;
    logic              r_div;
    logic [TW-1:0]     w_tnew_next;

    // Countdown saturates at zero so a ready result stays ready while it drains out.
    always_comb begin
        w_tnew_next = i_tnew;
        if (!LOAD_RAW) begin
            w_tnew_next = (i_tnew == '0) ? '0 : (i_tnew - TW'(1));
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_dst  <= '0;
            r_tnew <= '0;
            r_md   <= 1'b0;
            r_div  <= 1'b0;
        end else if (i_bubble) begin
            r_dst  <= '0;
            r_tnew <= '0;
            r_md   <= 1'b0;
            r_div  <= 1'b0;
        end else begin
            r_dst  <= i_dst;
            r_tnew <= w_tnew_next;
            r_md   <= i_md;
            r_div  <= i_div;
        end
    end

    assign o_dst  = r_dst;
    assign o_tnew = r_tnew;
    assign o_md   = r_md;
    assign o_div  = r_div;

endmodule

// File: rtl/hazard_fwd_unit.sv
// Pipeline hazard controller: tracks in-flight writers per stage, raises the single stall,
// picks forward sources for the D/E/M consumers and owns the mult/div busy counter.
module hazard_fwd_unit
    import hazard_pkg::*;
#(
    parameter int REG_AW   = DEF_REG_AW,
    parameter int STAGES   = DEF_STAGES,
    parameter int TW       = DEF_TW,
    parameter int MULT_LAT = DEF_MULT_LAT,
    parameter int DIV_LAT  = DEF_DIV_LAT,
    parameter int SW       = $clog2(STAGES + 1)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [REG_AW-1:0] i_d_rs,
    input  logic [REG_AW-1:0] i_d_rt,
    input  logic              i_d_rs_vld,
    input  logic              i_d_rt_vld,
    input  logic [TW-1:0]     i_d_rs_tuse,
    input  logic [TW-1:0]     i_d_rt_tuse,
    input  logic [REG_AW-1:0] i_d_dst,
    input  logic [TW-1:0]     i_d_tnew,
    input  logic              i_d_md_op,
    input  logic              i_d_md_div,
    input  logic              i_d_md_use,
    input  logic [REG_AW-1:0] i_e_rs,
    input  logic [REG_AW-1:0] i_e_rt,
    input  logic [REG_AW-1:0] i_m_rt,
    output logic              o_stall,
    output logic [SW-1:0]     o_d_fwd_rs,
    output logic [SW-1:0]     o_d_fwd_rt,
    output logic [SW-1:0]     o_e_fwd_rs,
    output logic [SW-1:0]     o_e_fwd_rt,
    output logic [SW-1:0]     o_m_fwd_rt,
    output logic              o_md_busy
);

    localparam int CW = $clog2(max_int(MULT_LAT, DIV_LAT) + 1);

    logic [REG_AW-1:0] w_dst  [1:STAGES];
    logic [TW-1:0]     w_tnew [1:STAGES];
    logic              w_md   [1:STAGES];
    logic              w_div  [1:STAGES];
    logic              w_stall;
    logic              w_md_busy;
    logic              w_unused_tail;
    logic [CW-1:0]     r_md_cnt;

    // Stage 1 (E) takes the D instruction or a bubble; later stages just shift and count down.
    for (genvar k = 1; k <= STAGES; k++) begin : g_stage
        if (k == 1) begin : g_first
            hazard_stage_reg #(
                .REG_AW  (REG_AW),
                .TW      (TW),
                .LOAD_RAW(1'b1)
            ) u_stage (
                .i_clk   (i_clk),
                .i_rst   (i_rst),
                .i_bubble(w_stall),
                .i_dst   (i_d_dst),
                .i_tnew  (i_d_tnew),
                .i_md    (i_d_md_op),
                .i_div   (i_d_md_div),
                .o_dst   (w_dst[k]),
                .o_tnew  (w_tnew[k]),
                .o_md    (w_md[k]),
                .o_div   (w_div[k])
            );
        end else begin : g_next
            hazard_stage_reg #(
                .REG_AW  (REG_AW),
                .TW      (TW),
                .LOAD_RAW(1'b0)
            ) u_stage (
                .i_clk   (i_clk),
                .i_rst   (i_rst),
                .i_bubble(1'b0),
                .i_dst   (w_dst[k-1]),
                .i_tnew  (w_tnew[k-1]),
                .i_md    (w_md[k-1]),
                .i_div   (w_div[k-1]),
                .o_dst   (w_dst[k]),
                .o_tnew  (w_tnew[k]),
                .o_md    (w_md[k]),
                .o_div   (w_div[k])
            );
        end
    end

    assign w_unused_tail = w_md[STAGES] ^ w_div[STAGES];

    // An operand is blocked when any in-flight writer of it produces later than it is needed.
    function automatic logic hazard_on(input logic [REG_AW-1:0] addr, input logic vld,
                                       input logic [TW-1:0] tuse);
        logic hit;
        hit = 1'b0;
        if (vld && (addr != '0)) begin
            for (int k = 1; k <= STAGES; k++) begin
                if ((w_dst[k] == addr) && (w_tnew[k] > tuse)) begin
                    hit = 1'b1;
                end
            end
        end
        return hit;
    endfunction

    // Youngest writer at or after 'first' decides; if it is not ready yet, fall back to FWD_RF.
    function automatic logic [SW-1:0] fwd_sel(input logic [REG_AW-1:0] addr, input int first);
        logic [SW-1:0] sel;
        sel = SW'(FWD_RF);
        if (addr != '0) begin
            for (int k = STAGES; k >= 1; k--) begin
                if ((k >= first) && (w_dst[k] == addr)) begin
                    sel = (w_tnew[k] == '0) ? SW'(k) : SW'(FWD_RF);
                end
            end
        end
        return sel;
    endfunction

    assign w_md_busy = w_md[1] | (r_md_cnt != '0);
    assign w_stall   = hazard_on(i_d_rs, i_d_rs_vld, i_d_rs_tuse)
                     | hazard_on(i_d_rt, i_d_rt_vld, i_d_rt_tuse)
                     | (i_d_md_use & w_md_busy);

    always_comb begin
        o_d_fwd_rs = fwd_sel(i_d_rs, 1);
        o_d_fwd_rt = fwd_sel(i_d_rt, 1);
        o_e_fwd_rs = fwd_sel(i_e_rs, 2);
        o_e_fwd_rt = fwd_sel(i_e_rt, 2);
        o_m_fwd_rt = fwd_sel(i_m_rt, 3);
    end

    // The counter loads from the op already sitting in E, independent of any stall in D.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_md_cnt <= '0;
        end else if (w_md[1]) begin
            r_md_cnt <= w_div[1] ? CW'(DIV_LAT) : CW'(MULT_LAT);
        end else if (r_md_cnt != '0) begin
            r_md_cnt <= r_md_cnt - CW'(1);
        end
    end

    assign o_stall   = w_stall;
    assign o_md_busy = w_md_busy;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed bench for hazard_fwd_unit: walks load-use, branch, $0, double-writer,
// mult/div busy and asynchronous-reset cases with hand-computed expectations.
module tb_hazard_fwd_unit;
    import hazard_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] dRs, dRt, dDst, eRs, eRt, mRt;
    logic       dRsVld, dRtVld, dMdOp, dMdDiv, dMdUse;
    logic [1:0] dRsTuse, dRtTuse, dTnew;
    logic       stall, mdBusy;
    logic [1:0] dFwdRs, dFwdRt, eFwdRs, eFwdRt, mFwdRt;
    int         total = 0;
    int         bad = 0;
    int         n;

    hazard_fwd_unit dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_d_rs     (dRs),
        .i_d_rt     (dRt),
        .i_d_rs_vld (dRsVld),
        .i_d_rt_vld (dRtVld),
        .i_d_rs_tuse(dRsTuse),
        .i_d_rt_tuse(dRtTuse),
        .i_d_dst    (dDst),
        .i_d_tnew   (dTnew),
        .i_d_md_op  (dMdOp),
        .i_d_md_div (dMdDiv),
        .i_d_md_use (dMdUse),
        .i_e_rs     (eRs),
        .i_e_rt     (eRt),
        .i_m_rt     (mRt),
        .o_stall    (stall),
        .o_d_fwd_rs (dFwdRs),
        .o_d_fwd_rt (dFwdRt),
        .o_e_fwd_rs (eFwdRs),
        .o_e_fwd_rt (eFwdRt),
        .o_m_fwd_rt (mFwdRt),
        .o_md_busy  (mdBusy)
    );

    always #5 clk = ~clk;

    function automatic hz_entry_t mkEnt(input logic [4:0] dst, input logic [1:0] tnew,
                                        input logic md, input logic dv);
        hz_entry_t e;
        e.dst  = dst;
        e.tnew = tnew;
        e.md   = md;
        e.div  = dv;
        return e;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [4:0] rs, input logic rsVld, input logic [1:0] rsTuse,
                                 input logic [4:0] rt, input logic rtVld, input logic [1:0] rtTuse,
                                 input hz_entry_t ent, input logic mdUse);
        dRs     = rs;
        dRsVld  = rsVld;
        dRsTuse = rsTuse;
        dRt     = rt;
        dRtVld  = rtVld;
        dRtTuse = rtTuse;
        dDst    = ent.dst;
        dTnew   = ent.tnew;
        dMdOp   = ent.md;
        dMdDiv  = ent.div;
        dMdUse  = mdUse;
        #1;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        eRs = 5'd0;
        eRt = 5'd0;
        mRt = 5'd0;
        applyStimulus(0, 0, 0, 0, 0, 0, mkEnt(0, 0, 0, 0), 0);
        checkOutput("rst_stall", stall, 0);
        checkOutput("rst_busy", mdBusy, 0);
        checkOutput("rst_dfwd", dFwdRs, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        checkOutput("post_rst_stall", stall, 0);

        // lw $1 then addu $2,$1,$3
        applyStimulus(0, 0, 0, 0, 0, 0, mkEnt(5'd1, 2'd2, 0, 0), 0);
        checkOutput("lw_issue_stall", stall, 0);
        nextCycle();
        applyStimulus(5'd1, 1, 2'd1, 5'd3, 1, 2'd1, mkEnt(5'd2, 2'd1, 0, 0), 0);
        checkOutput("lu_stall1", stall, 1);
        checkOutput("lu_dfwd_notready", dFwdRs, 0);
        nextCycle();
        checkOutput("lu_stall_released", stall, 0);
        checkOutput("lu_dfwd_m", dFwdRs, 0);
        nextCycle();
        eRs = 5'd1;
        eRt = 5'd3;
        mRt = 5'd1;
        applyStimulus(5'd1, 1, 2'd1, 0, 0, 0, mkEnt(0, 0, 0, 0), 0);
        checkOutput("lu_efwd_rs_w", eFwdRs, 3);
        checkOutput("lu_efwd_rt_none", eFwdRt, 0);
        checkOutput("lu_dfwd_w", dFwdRs, 3);
        checkOutput("lu_mfwd_w", mFwdRt, 3);
        checkOutput("lu_nostall", stall, 0);

        // addu result consumed in E one cycle later, then addu $4 / beq $4,$2
        nextCycle();
        eRs = 5'd2;
        eRt = 5'd0;
        mRt = 5'd2;
        applyStimulus(0, 0, 0, 0, 0, 0, mkEnt(5'd4, 2'd1, 0, 0), 0);
        checkOutput("alu_efwd_m", eFwdRs, 2);
        checkOutput("alu_mfwd_bubble", mFwdRt, 0);
        checkOutput("alu_stall", stall, 0);
        nextCycle();
        eRs = 5'd0;
        mRt = 5'd0;
        applyStimulus(5'd4, 1, 2'd0, 5'd2, 1, 2'd0, mkEnt(0, 0, 0, 0), 0);
        checkOutput("beq_stall", stall, 1);
        checkOutput("beq_dfwd_rs_notready", dFwdRs, 0);
        checkOutput("beq_dfwd_rt_w", dFwdRt, 3);
        nextCycle();
        checkOutput("beq_stall_released", stall, 0);
        checkOutput("beq_dfwd_rs_m", dFwdRs, 2);
        checkOutput("beq_dfwd_rt_gone", dFwdRt, 0);

        // addu $0 then use $0
        nextCycle();
        applyStimulus(5'd4, 1, 2'd0, 0, 0, 0, mkEnt(0, 2'd1, 0, 0), 0);
        checkOutput("zero_w_fwd", dFwdRs, 3);
        checkOutput("zero_issue_stall", stall, 0);
        nextCycle();
        applyStimulus(0, 1, 2'd0, 0, 1, 2'd0, mkEnt(0, 0, 0, 0), 0);
        checkOutput("zero_stall", stall, 0);
        checkOutput("zero_dfwd_rs", dFwdRs, 0);
        checkOutput("zero_dfwd_rt", dFwdRt, 0);
        checkOutput("zero_efwd_rs", eFwdRs, 0);

        // two writers of $5 in E and M, reader in D
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, mkEnt(5'd5, 2'd0, 0, 0), 0);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, mkEnt(5'd5, 2'd0, 0, 0), 0);
        nextCycle();
        eRs = 5'd5;
        mRt = 5'd5;
        applyStimulus(5'd5, 1, 2'd0, 5'd5, 1, 2'd1, mkEnt(0, 0, 0, 0), 0);
        checkOutput("dual_dfwd_rs", dFwdRs, 1);
        checkOutput("dual_dfwd_rt", dFwdRt, 1);
        checkOutput("dual_efwd_rs", eFwdRs, 2);
        checkOutput("dual_mfwd_rt", mFwdRt, 0);
        checkOutput("dual_stall", stall, 0);
        eRs = 5'd0;
        mRt = 5'd0;

        // div then mflo immediately: 1 + DIV_LAT stall cycles
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, mkEnt(0, 0, 1, 1), 1);
        checkOutput("div_issue_stall", stall, 0);
        checkOutput("div_issue_busy", mdBusy, 0);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, mkEnt(5'd6, 2'd1, 0, 0), 1);
        checkOutput("mflo_busy", mdBusy, 1);
        n = 0;
        while (stall === 1'b1 && n < 40) begin
            n++;
            nextCycle();
        end
        checkOutput("div_stall_cycles", n, 11);
        checkOutput("div_busy_dropped", mdBusy, 0);

        // mult: busy for 1 + MULT_LAT cycles
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, mkEnt(0, 0, 1, 0), 1);
        checkOutput("mult_issue_stall", stall, 0);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, mkEnt(0, 0, 0, 0), 0);
        n = 0;
        while (mdBusy === 1'b1 && n < 40) begin
            n++;
            nextCycle();
        end
        checkOutput("mult_busy_cycles", n, 6);

        // reset during div countdown
        applyStimulus(0, 0, 0, 0, 0, 0, mkEnt(0, 0, 1, 1), 1);
        checkOutput("div2_issue_stall", stall, 0);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, mkEnt(5'd7, 2'd1, 0, 0), 1);
        repeat (5) nextCycle();
        checkOutput("div2_stall_pre_rst", stall, 1);
        checkOutput("div2_busy_pre_rst", mdBusy, 1);
        #2 rst = 1'b1;
        #1;
        checkOutput("rst_mid_busy", mdBusy, 0);
        checkOutput("rst_mid_stall", stall, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        checkOutput("rst_after_busy", mdBusy, 0);
        checkOutput("rst_after_stall", stall, 0);
        nextCycle();
        checkOutput("rst_after2_busy", mdBusy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
